// File: rtl/bus_mgr_regfile.sv
// bus_mgr_regfile: target on the as/rw/ds/da strobe bus with a DEPTH-entry
// register file, programmable wait states, abort on strobe loss, an
// out-of-range error flag and a wrapping count of acknowledged transfers.
//
// Ports:
//   clk      - bus clock, rising-edge active
//   rst      - asynchronous, active-high reset
//   as       - address strobe, high for the whole transfer
//   rw       - 1 = read, 0 = write
//   ds       - data strobe; high requests, low releases
//   addr     - register address
//   wdata    - write data
//   rdata    - read data, valid while da is high on reads
//   da       - data acknowledge
//   err      - high with da when the latched address is >= DEPTH
//   xfer_cnt - number of acknowledged transfers, wraps at 16 bits
module bus_mgr_regfile #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              as,
  input  logic              rw,
  input  logic              ds,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              da,
  output logic              err,
  output logic [15:0]       xfer_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t            r_state;
  logic [7:0]        r_wcnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_da;
  logic              r_err;
  logic [15:0]       r_xfer_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_go;
  logic              w_enter_ack;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  // With zero wait states the access happens on the accepting edge itself,
  // so the transfer attributes come straight from the bus rather than from
  // the latches that are being loaded on that same edge.
  always_comb begin
    w_go        = as && ds;
    w_enter_ack = 1'b0;
    if (r_state == IDLE && w_go && WAIT_CYCLES == 0) begin
      w_enter_ack = 1'b1;
    end
    if (r_state == WAIT && w_go && r_wcnt == 8'd1) begin
      w_enter_ack = 1'b1;
    end
    w_rw       = (r_state == IDLE) ? rw    : r_rw;
    w_addr     = (r_state == IDLE) ? addr  : r_addr;
    w_wdata    = (r_state == IDLE) ? wdata : r_wdata;
    w_in_range = ({1'b0, w_addr} < (ADDR_W + 1)'(DEPTH));
    w_idx      = w_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wcnt     <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_da       <= 1'b0;
      r_err      <= 1'b0;
      r_xfer_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_rw    <= rw;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wcnt  <= 8'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          // Losing either strobe abandons the transfer before any side effect.
          if (!w_go) begin
            r_state <= IDLE;
          end else if (r_wcnt == 8'd1) begin
            r_state <= ACK;
          end else begin
            r_wcnt <= r_wcnt - 8'd1;
          end
        end
        ACK: begin
          // Only ds releases the acknowledge; as and data are ignored here.
          if (!ds) begin
            r_da    <= 1'b0;
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_enter_ack) begin
        r_da       <= 1'b1;
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
        if (w_in_range) begin
          if (w_rw) begin
            r_rdata <= r_mem[w_idx];
          end else begin
            r_mem[w_idx] <= w_wdata;
          end
        end else begin
          r_rdata <= '1;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign rdata    = r_rdata;
  assign da       = r_da;
  assign err      = r_err;
  assign xfer_cnt = r_xfer_cnt;

endmodule
